weekly_alarm: RTL and testbench

//  Downstream consumer of weekcounter: compares live s/m/h/w time against a programmed
//  hh:mm alarm with a 7-bit weekday mask, and drives ring/snooze outputs.

---
 rtl/weekly_alarm_pkg.sv | 21 ++
 rtl/weekly_alarm_if.sv | 31 +++
 rtl/weekly_alarm_hm_add.sv | 25 ++
 rtl/weekly_alarm.sv | 150 +++++++++++++++
 tb/tb_weekly_alarm.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/weekly_alarm_pkg.sv
// Shared time limits, FSM state codes and a setting validity helper.
package weekly_alarm_pkg;

   localparam int SEC_MAX  = 59;
   localparam int MIN_MAX  = 59;
   localparam int HOUR_MAX = 23;
   localparam int WDAY_MAX = 6;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARMED = 2'd1,
      ST_RING  = 2'd2,
      ST_SNZ   = 2'd3
   } state_t;

   // True when hh:mm is a legal time of day.
   function automatic logic hm_valid(input logic [4:0] hh, input logic [5:0] mm);
      return (hh <= 5'(HOUR_MAX)) && (mm <= 6'(MIN_MAX));
   endfunction

endpackage

// File: rtl/weekly_alarm_if.sv
// Time inputs, alarm programming, user controls and status outputs of the alarm.
interface weekly_alarm_if;

   logic [5:0] s;
   logic [5:0] m;
   logic [4:0] h;
   logic [2:0] w;
   logic       set_en;
   logic [4:0] set_h;
   logic [5:0] set_m;
   logic [6:0] set_wmask;
   logic       arm;
   logic       disarm;
   logic       snooze;
   logic       stop;
   logic       ring;
   logic       snoozing;
   logic       armed;
   logic [1:0] snooze_cnt;

   modport master (
      output s, m, h, w, set_en, set_h, set_m, set_wmask, arm, disarm, snooze, stop,
      input  ring, snoozing, armed, snooze_cnt
   );

   modport slave (
      input  s, m, h, w, set_en, set_h, set_m, set_wmask, arm, disarm, snooze, stop,
      output ring, snoozing, armed, snooze_cnt
   );

endinterface

// File: rtl/weekly_alarm_hm_add.sv
// Combinational hh:mm + minutes with minute carry and midnight wrap.
module hm_add
   import weekly_alarm_pkg::*;
(
   input  logic [4:0] h_in,
   input  logic [5:0] m_in,
   input  logic [5:0] add,
   output logic [4:0] h_out,
   output logic [5:0] m_out
);

   logic [6:0] m_sum;

   // Sum in 7 bits so the carry out of the minute field is never lost.
   always_comb begin
      m_sum = {1'b0, m_in} + {1'b0, add};
      h_out = h_in;
      m_out = m_sum[5:0];
      if (m_sum > 7'(MIN_MAX)) begin
         m_out = 6'(m_sum - 7'(MIN_MAX + 1));
         h_out = (h_in >= 5'(HOUR_MAX)) ? 5'd0 : h_in + 5'd1;
      end
   end

endmodule

// File: rtl/weekly_alarm.sv
// Weekly alarm: hh:mm + weekday-mask match against live time, ring/snooze FSM,
// snooze wake time and ring auto-stop timer.
module weekly_alarm
   import weekly_alarm_pkg::*;
#(
   parameter int SNOOZE_MIN = 5,
   parameter int RING_SEC   = 60,
   parameter int MAX_SNOOZE = 3
) (
   input logic           clk,
   input logic           rst,
   weekly_alarm_if.slave bus
);

   localparam logic [7:0] RING_LIM = 8'(RING_SEC);
   localparam logic [1:0] SNZ_LIM  = 2'(MAX_SNOOZE);
   localparam logic [5:0] SNZ_ADD  = 6'(SNOOZE_MIN);

   state_t     state, state_n;
   logic [4:0] alarm_h, wake_h, nxt_h;
   logic [5:0] alarm_m, wake_m, nxt_m;
   logic [6:0] wmask;
   logic [5:0] s_q;
   logic       match_q, wake_q;
   logic [7:0] timer, timer_n;
   logic [1:0] cnt, cnt_n;
   logic       wake_ld;
   logic       ring_q, snz_q, armed_q;

   logic match_c, wake_c, match_edge, wake_edge, tick;

   // Weekday is range-checked first so w==7 never selects a mask bit.
   assign match_c = (bus.s == 6'd0) && (bus.m == alarm_m) && (bus.h == alarm_h)
                  && (bus.w <= 3'(WDAY_MAX)) && wmask[bus.w];
   assign wake_c     = (bus.s == 6'd0) && (bus.m == wake_m) && (bus.h == wake_h);
   assign match_edge = match_c && !match_q;
   assign wake_edge  = wake_c && !wake_q;
   assign tick       = (bus.s != s_q);

   hm_add u_hm_add (
      .h_in  (bus.h),
      .m_in  (bus.m),
      .add   (SNZ_ADD),
      .h_out (nxt_h),
      .m_out (nxt_m)
   );

   // Next state, snooze count and ring timer; disarm overrides every state.
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      timer_n = timer;
      wake_ld = 1'b0;
      if (bus.disarm) begin
         state_n = ST_IDLE;
         cnt_n   = 2'd0;
         timer_n = 8'd0;
      end else begin
         case (state)
            ST_IDLE: if (bus.arm) state_n = ST_ARMED;
            ST_ARMED: if (match_edge) begin
               state_n = ST_RING;
               timer_n = 8'd0;
               cnt_n   = 2'd0;
            end
            ST_RING: begin
               if (bus.stop) begin
                  state_n = ST_ARMED;
                  cnt_n   = 2'd0;
               end else if (bus.snooze && (cnt < SNZ_LIM)) begin
                  state_n = ST_SNZ;
                  cnt_n   = cnt + 2'd1;
                  wake_ld = 1'b1;
               end else if (tick) begin
                  // A snooze refused at the limit falls through so the timer still runs.
                  if (timer + 8'd1 == RING_LIM) begin
                     state_n = ST_ARMED;
                     cnt_n   = 2'd0;
                     timer_n = 8'd0;
                  end else begin
                     timer_n = timer + 8'd1;
                  end
               end
            end
            ST_SNZ: begin
               if (bus.stop) begin
                  state_n = ST_ARMED;
                  cnt_n   = 2'd0;
               end else if (wake_edge) begin
                  state_n = ST_RING;
                  timer_n = 8'd0;
               end
            end
            default: state_n = ST_IDLE;
         endcase
      end
   end

   // State, counters and registered status outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         cnt     <= 2'd0;
         timer   <= 8'd0;
         ring_q  <= 1'b0;
         snz_q   <= 1'b0;
         armed_q <= 1'b0;
      end else begin
         state   <= state_n;
         cnt     <= cnt_n;
         timer   <= timer_n;
         ring_q  <= (state_n == ST_RING);
         snz_q   <= (state_n == ST_SNZ);
         armed_q <= (state_n != ST_IDLE);
      end
   end

   // Alarm setting, wake time and the edge/tick history registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         alarm_h <= 5'd0;
         alarm_m <= 6'd0;
         wmask   <= 7'd0;
         wake_h  <= 5'd0;
         wake_m  <= 6'd0;
         s_q     <= 6'd0;
         match_q <= 1'b0;
         wake_q  <= 1'b0;
      end else begin
         if (bus.set_en && hm_valid(bus.set_h, bus.set_m)) begin
            alarm_h <= bus.set_h;
            alarm_m <= bus.set_m;
            wmask   <= bus.set_wmask;
         end
         if (wake_ld) begin
            wake_h <= nxt_h;
            wake_m <= nxt_m;
         end
         s_q     <= bus.s;
         match_q <= match_c;
         wake_q  <= wake_c;
      end
   end

   assign bus.ring       = ring_q;
   assign bus.snoozing   = snz_q;
   assign bus.armed      = armed_q;
   assign bus.snooze_cnt = cnt;

endmodule

// File: tb/tb_weekly_alarm.sv
// Directed bench for weekly_alarm: match, snooze, auto-stop, wrap, priority, reset.
module tb_weekly_alarm;

   logic clk;
   logic rst;
   int   checks;
   int   failures;

   weekly_alarm_if bus();

   weekly_alarm #(.SNOOZE_MIN(5), .RING_SEC(60), .MAX_SNOOZE(3)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Status vector {ring, snoozing, armed, snooze_cnt}.
   logic [4:0] st;
   assign st = {bus.ring, bus.snoozing, bus.armed, bus.snooze_cnt};

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [4:0] hh, input logic [5:0] mm,
                        input logic [5:0] ss, input logic [2:0] ww);
      bus.h = hh; bus.m = mm; bus.s = ss; bus.w = ww;
   endtask

   task automatic program_alarm(input logic [4:0] hh, input logic [5:0] mm,
                                input logic [6:0] mask);
      bus.set_en = 1'b1; bus.set_h = hh; bus.set_m = mm; bus.set_wmask = mask;
      step();
      bus.set_en = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step(); step();
      rst = 1'b0;
      checks++;
      if (st !== 5'b00000) begin failures++; $display("FAIL reset_status got=%b exp=00000", st); end
   endtask

   task automatic test_match();
      program_alarm(5'd7, 6'd30, 7'b0000010);
      bus.arm = 1'b1; step(); bus.arm = 1'b0;
      checks++;
      if (st !== 5'b00100) begin failures++; $display("FAIL arm got=%b exp=00100", st); end
      drive(5'd7, 6'd29, 6'd59, 3'd2); step();
      drive(5'd7, 6'd30, 6'd0, 3'd2);  step(); step();
      checks++;
      if (st !== 5'b00100) begin failures++; $display("FAIL masked_day got=%b exp=00100", st); end
      drive(5'd7, 6'd30, 6'd1, 3'd2);  step();
      drive(5'd7, 6'd29, 6'd59, 3'd1); step();
      drive(5'd7, 6'd30, 6'd0, 3'd1);  step();
      checks++;
      if (st !== 5'b10100) begin failures++; $display("FAIL match_ring got=%b exp=10100", st); end
   endtask

   task automatic test_snooze();
      drive(5'd7, 6'd30, 6'd10, 3'd1); bus.snooze = 1'b1; step(); bus.snooze = 1'b0;
      checks++;
      if (st !== 5'b01101) begin failures++; $display("FAIL snooze1 got=%b exp=01101", st); end
      drive(5'd7, 6'd34, 6'd59, 3'd1); step();
      checks++;
      if (st !== 5'b01101) begin failures++; $display("FAIL snooze_hold got=%b exp=01101", st); end
      drive(5'd7, 6'd35, 6'd0, 3'd1); step();
      checks++;
      if (st !== 5'b10101) begin failures++; $display("FAIL wake_ring got=%b exp=10101", st); end
   endtask

   task automatic test_timeout();
      for (int sec = 1; sec <= 59; sec++) begin
         drive(5'd7, 6'd35, 6'(sec), 3'd1);
         step(); step();
      end
      checks++;
      if (st !== 5'b10101) begin failures++; $display("FAIL tick59_ring got=%b exp=10101", st); end
      drive(5'd7, 6'd36, 6'd0, 3'd1); step();
      checks++;
      if (st !== 5'b00100) begin failures++; $display("FAIL auto_stop got=%b exp=00100", st); end
   endtask

   task automatic test_wrap_limit();
      program_alarm(5'd23, 6'd58, 7'b0001000);
      drive(5'd23, 6'd57, 6'd59, 3'd3); step();
      drive(5'd23, 6'd58, 6'd0, 3'd3);  step();
      checks++;
      if (st !== 5'b10100) begin failures++; $display("FAIL ring_2358 got=%b exp=10100", st); end
      drive(5'd23, 6'd58, 6'd5, 3'd3); bus.snooze = 1'b1; step(); bus.snooze = 1'b0;
      checks++;
      if (st !== 5'b01101) begin failures++; $display("FAIL wrap_snooze got=%b exp=01101", st); end
      drive(5'd0, 6'd1, 6'd59, 3'd4); step();
      drive(5'd0, 6'd2, 6'd0, 3'd4);  step();
      checks++;
      if (st !== 5'b01101) begin failures++; $display("FAIL early_wake got=%b exp=01101", st); end
      drive(5'd0, 6'd2, 6'd59, 3'd4); step();
      drive(5'd0, 6'd3, 6'd0, 3'd4);  step();
      checks++;
      if (st !== 5'b10101) begin failures++; $display("FAIL wake_0003 got=%b exp=10101", st); end
      drive(5'd0, 6'd3, 6'd5, 3'd4); bus.snooze = 1'b1; step(); bus.snooze = 1'b0;
      checks++;
      if (st !== 5'b01110) begin failures++; $display("FAIL snooze2 got=%b exp=01110", st); end
      drive(5'd0, 6'd7, 6'd59, 3'd4); step();
      drive(5'd0, 6'd8, 6'd0, 3'd4);  step();
      checks++;
      if (st !== 5'b10110) begin failures++; $display("FAIL wake_0008 got=%b exp=10110", st); end
      drive(5'd0, 6'd8, 6'd5, 3'd4); bus.snooze = 1'b1; step(); bus.snooze = 1'b0;
      checks++;
      if (st !== 5'b01111) begin failures++; $display("FAIL snooze3 got=%b exp=01111", st); end
      drive(5'd0, 6'd12, 6'd59, 3'd4); step();
      drive(5'd0, 6'd13, 6'd0, 3'd4);  step();
      checks++;
      if (st !== 5'b10111) begin failures++; $display("FAIL wake_0013 got=%b exp=10111", st); end
      drive(5'd0, 6'd13, 6'd5, 3'd4); bus.snooze = 1'b1; step(); bus.snooze = 1'b0;
      checks++;
      if (st !== 5'b10111) begin failures++; $display("FAIL snooze4_ignored got=%b exp=10111", st); end
   endtask

   task automatic test_priority();
      bus.snooze = 1'b1; bus.stop = 1'b1; step(); bus.snooze = 1'b0; bus.stop = 1'b0;
      checks++;
      if (st !== 5'b00100) begin failures++; $display("FAIL stop_beats_snooze got=%b exp=00100", st); end
      drive(5'd23, 6'd57, 6'd59, 3'd3); step();
      drive(5'd23, 6'd58, 6'd0, 3'd3);  step();
      checks++;
      if (st !== 5'b10100) begin failures++; $display("FAIL rering got=%b exp=10100", st); end
      bus.stop = 1'b1; step(); bus.stop = 1'b0;
      checks++;
      if (st !== 5'b00100) begin failures++; $display("FAIL stop got=%b exp=00100", st); end
      step(); step();
      checks++;
      if (st !== 5'b00100) begin failures++; $display("FAIL once_per_minute got=%b exp=00100", st); end
      drive(5'd23, 6'd58, 6'd1, 3'd3); step();
      drive(5'd23, 6'd58, 6'd0, 3'd3); step();
      checks++;
      if (st !== 5'b10100) begin failures++; $display("FAIL new_edge got=%b exp=10100", st); end
      bus.disarm = 1'b1; bus.arm = 1'b1; step(); bus.disarm = 1'b0; bus.arm = 1'b0;
      checks++;
      if (st !== 5'b00000) begin failures++; $display("FAIL disarm got=%b exp=00000", st); end
   endtask

   task automatic test_bad_set_and_reset();
      bus.arm = 1'b1; step(); bus.arm = 1'b0;
      checks++;
      if (st !== 5'b00100) begin failures++; $display("FAIL rearm got=%b exp=00100", st); end
      program_alarm(5'd24, 6'd10, 7'b0000000);
      program_alarm(5'd23, 6'd60, 7'b0000000);
      drive(5'd23, 6'd57, 6'd59, 3'd3); step();
      drive(5'd23, 6'd58, 6'd0, 3'd3);  step();
      checks++;
      if (st !== 5'b10100) begin failures++; $display("FAIL bad_set_ignored got=%b exp=10100", st); end
      program_alarm(5'd6, 6'd0, 7'b1111111);
      checks++;
      if (st !== 5'b10100) begin failures++; $display("FAIL set_keeps_state got=%b exp=10100", st); end
      rst = 1'b1; step(); rst = 1'b0;
      checks++;
      if (st !== 5'b00000) begin failures++; $display("FAIL reset_mid_ring got=%b exp=00000", st); end
      bus.arm = 1'b1; step(); bus.arm = 1'b0;
      drive(5'd5, 6'd59, 6'd59, 3'd3); step();
      drive(5'd6, 6'd0, 6'd0, 3'd3);   step();
      checks++;
      if (st !== 5'b00100) begin failures++; $display("FAIL reset_cleared_mask got=%b exp=00100", st); end
   endtask

   initial begin
      checks = 0; failures = 0;
      rst = 1'b1;
      bus.s = '0; bus.m = '0; bus.h = '0; bus.w = '0;
      bus.set_en = 1'b0; bus.set_h = '0; bus.set_m = '0; bus.set_wmask = '0;
      bus.arm = 1'b0; bus.disarm = 1'b0; bus.snooze = 1'b0; bus.stop = 1'b0;
      test_reset();
      test_match();
      test_snooze();
      test_timeout();
      test_wrap_limit();
      test_priority();
      test_bad_set_and_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
